// File: rtl/pwm_fade_sched.sv
// Round-robin scheduler that shares one fade LED among NUM_REQ event sources.
// Optional per-requester coalesced-event counters are built when PWM_FADE_SCHED_STATS_EN is defined.
module pwm_fade_sched #(
   parameter int          NUM_REQ     = 4,
   parameter int          SEL_W       = 2,
   parameter int unsigned HOLD_CYCLES = 16777216
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NUM_REQ-1:0]   req,
   output logic                 trigger,
   output logic [SEL_W-1:0]     sel,
   output logic                 busy,
   output logic [NUM_REQ-1:0]   pending,
   output logic [8*NUM_REQ-1:0] coalesce_cnt
);

   localparam logic [1:0]       ST_IDLE   = 2'd0;
   localparam logic [1:0]       ST_FIRE   = 2'd1;
   localparam logic [1:0]       ST_HOLD   = 2'd2;
   localparam logic [31:0]      HOLD_LOAD = 32'(HOLD_CYCLES - 1);
   localparam logic [SEL_W:0]   NUM_REQ_W = (SEL_W + 1)'(NUM_REQ);

   logic [1:0]           state_reg, state_next;
   logic [31:0]          hold_cnt_reg, hold_cnt_next;
   logic [SEL_W-1:0]     sel_reg, sel_next;
   logic [SEL_W-1:0]     last_grant_reg, last_grant_next;
   logic [NUM_REQ-1:0]   pending_reg, pending_next;
   logic [NUM_REQ-1:0]   fire_mask, clr_mask;

   logic [2*NUM_REQ-1:0] pend_dbl;
   logic [NUM_REQ-1:0]   pend_rot;
   logic [SEL_W:0]       rot_base, win_sum;
   logic [SEL_W-1:0]     win_off;
   logic                 win_found;

   genvar gi;

   for (gi = 0; gi < NUM_REQ; gi++) begin : g_fire_mask
      assign fire_mask[gi] = (state_reg == ST_FIRE) && (sel_reg == SEL_W'(gi));
   end

   // A req coinciding with its own FIRE re-arms the flag instead of being lost.
   assign clr_mask     = fire_mask & ~req;
   assign pending_next = (pending_reg & ~clr_mask) | req;

   // Rotate pending so bit 0 is last_grant+1, take the lowest set bit, then un-rotate.
   always_comb begin
      pend_dbl  = {pending_reg, pending_reg};
      rot_base  = {1'b0, last_grant_reg} + 1'b1;
      pend_rot  = pend_dbl[rot_base +: NUM_REQ];
      win_found = 1'b0;
      win_off   = '0;
      for (int j = NUM_REQ - 1; j >= 0; j--) begin
         if (pend_rot[j]) begin
            win_found = 1'b1;
            win_off   = SEL_W'(j);
         end
      end
      win_sum = rot_base + {1'b0, win_off};
      if (win_sum >= NUM_REQ_W) begin
         win_sum = win_sum - NUM_REQ_W;
      end
   end

   always_comb begin
      state_next      = state_reg;
      hold_cnt_next   = hold_cnt_reg;
      sel_next        = sel_reg;
      last_grant_next = last_grant_reg;
      case (state_reg)
         ST_IDLE: begin
            if (win_found) begin
               sel_next        = win_sum[SEL_W-1:0];
               last_grant_next = win_sum[SEL_W-1:0];
               state_next      = ST_FIRE;
            end
         end
         ST_FIRE: begin
            hold_cnt_next = HOLD_LOAD;
            state_next    = ST_HOLD;
         end
         ST_HOLD: begin
            if (hold_cnt_reg == 32'd0) begin
               state_next = ST_IDLE;
            end else begin
               hold_cnt_next = hold_cnt_reg - 32'd1;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg      <= ST_IDLE;
         hold_cnt_reg   <= '0;
         sel_reg        <= '0;
         last_grant_reg <= SEL_W'(NUM_REQ - 1);
         pending_reg    <= '0;
      end else begin
         state_reg      <= state_next;
         hold_cnt_reg   <= hold_cnt_next;
         sel_reg        <= sel_next;
         last_grant_reg <= last_grant_next;
         pending_reg    <= pending_next;
      end
   end

   // Outputs are forced low in the reset cycle so an aborted window never fires.
   assign trigger = (state_reg == ST_FIRE) && !reset;
   assign busy    = ((state_reg == ST_FIRE) || (state_reg == ST_HOLD)) && !reset;
   assign sel     = sel_reg;
   assign pending = pending_reg;

`ifdef PWM_FADE_SCHED_STATS_EN
   for (gi = 0; gi < NUM_REQ; gi++) begin : g_stats
      logic [7:0] cnt_reg;
      always_ff @(posedge clk) begin
         if (reset) begin
            cnt_reg <= '0;
         end else if (req[gi] && pending_reg[gi] && !clr_mask[gi] && (cnt_reg != 8'hFF)) begin
            cnt_reg <= cnt_reg + 8'd1;
         end
      end
      assign coalesce_cnt[8*gi +: 8] = cnt_reg;
   end
`else
   assign coalesce_cnt = '0;
`endif

endmodule

// File: tb/tb_pwm_fade_sched.sv
// Directed bench for pwm_fade_sched (NUM_REQ=4, HOLD_CYCLES=4) with hand-computed expectations.
module tb_pwm_fade_sched;

   logic        clk;
   logic        reset;
   logic [3:0]  req;
   logic        trigger;
   logic [1:0]  sel;
   logic        busy;
   logic [3:0]  pending;
   logic [31:0] coalesce_cnt;

   int n_checks = 0;
   int n_pass   = 0;

   pwm_fade_sched #(
      .NUM_REQ     (4),
      .SEL_W       (2),
      .HOLD_CYCLES (4)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .req          (req),
      .trigger      (trigger),
      .sel          (sel),
      .busy         (busy),
      .pending      (pending),
      .coalesce_cnt (coalesce_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance n rising edges and settle just after the last one.
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      req   = 4'b0000;
      tick(2);
      chk("rst_trigger", 32'(trigger), 32'd0);
      chk("rst_busy",    32'(busy),    32'd0);
      chk("rst_pending", 32'(pending), 32'd0);
      chk("rst_sel",     32'(sel),     32'd0);
      chk("rst_coal",    coalesce_cnt, 32'd0);
      reset = 1'b0;
   endtask

   initial begin
      logic [3:0]  exp_p;
      logic [31:0] exp_coal;
      reset = 1'b1;
      req   = 4'b0000;
      tick(1);

      // Single request: latency 2, busy for FIRE plus 4 hold cycles.
      $display("txn single: req=0001");
      do_reset();
      tick(3);
      req = 4'b0001;
      chk("t1_trig_t0", 32'(trigger), 32'd0);
      tick(1);
      req = 4'b0000;
      chk("t1_pend_t1", 32'(pending), 32'h1);
      chk("t1_trig_t1", 32'(trigger), 32'd0);
      chk("t1_busy_t1", 32'(busy),    32'd0);
      tick(1);
      chk("t1_trig_t2", 32'(trigger), 32'd1);
      chk("t1_sel_t2",  32'(sel),     32'd0);
      chk("t1_busy_t2", 32'(busy),    32'd1);
      tick(1);
      chk("t1_pend_t3", 32'(pending), 32'h0);
      for (int k = 3; k <= 6; k++) begin
         chk("t1_busy_hold", 32'(busy),    32'd1);
         chk("t1_trig_hold", 32'(trigger), 32'd0);
         tick(1);
      end
      chk("t1_busy_t7", 32'(busy), 32'd0);
      chk("t1_sel_keep", 32'(sel), 32'd0);

      // All four lines at once: grants 0..3, one per 6-cycle window.
      $display("txn all: req=1111");
      do_reset();
      req = 4'b1111;
      tick(1);
      req = 4'b0000;
      chk("t2_pend_t1", 32'(pending), 32'hF);
      tick(1);
      for (int g = 0; g < 4; g++) begin
         exp_p = 4'hF << g;
         for (int off = 0; off < 6; off++) begin
            chk("t2_trig", 32'(trigger), (off == 0) ? 32'd1 : 32'd0);
            if (off == 0) begin
               chk("t2_sel",  32'(sel),     32'(g));
               chk("t2_pend", 32'(pending), 32'(exp_p));
            end
            tick(1);
         end
      end
      chk("t2_pend_end", 32'(pending), 32'h0);
      chk("t2_busy_end", 32'(busy),    32'd0);

      // Three req[2] pulses during requester 1's hold merge into one grant.
      $display("txn coalesce: req=0010 then req[2] x3");
      do_reset();
      req = 4'b0010;
      tick(1);
      req = 4'b0000;
      tick(1);
      chk("t3_sel1", 32'(sel), 32'd1);
      chk("t3_trig1", 32'(trigger), 32'd1);
      tick(1);
      req = 4'b0100;
      tick(3);
      req = 4'b0000;
      chk("t3_pend_hold", 32'(pending), 32'h4);
      tick(2);
      chk("t3_trig2", 32'(trigger), 32'd1);
      chk("t3_sel2",  32'(sel),     32'd2);
`ifdef PWM_FADE_SCHED_STATS_EN
      exp_coal = 32'h0002_0000;
`else
      exp_coal = 32'h0;
`endif
      chk("t3_coal", coalesce_cnt, exp_coal);
      for (int k = 0; k < 8; k++) begin
         tick(1);
         chk("t3_no_retrig", 32'(trigger), 32'd0);
      end

      // req[0] during its own FIRE keeps pending[0]; 1 is served before 0 again.
      $display("txn rearm: req=0011, req[0] during FIRE");
      do_reset();
      req = 4'b0011;
      tick(1);
      req = 4'b0000;
      tick(1);
      chk("t4_sel0", 32'(sel), 32'd0);
      req = 4'b0001;
      tick(1);
      req = 4'b0000;
      chk("t4_pend_keep", 32'(pending), 32'h3);
      tick(5);
      chk("t4_trig_b", 32'(trigger), 32'd1);
      chk("t4_sel_b",  32'(sel),     32'd1);
      tick(6);
      chk("t4_trig_c", 32'(trigger), 32'd1);
      chk("t4_sel_c",  32'(sel),     32'd0);

      // Reset during HOLD aborts the window and flushes pending.
      $display("txn abort: reset during HOLD with pending=0110");
      do_reset();
      req = 4'b0001;
      tick(1);
      req = 4'b0000;
      tick(2);
      req = 4'b0110;
      tick(1);
      req = 4'b0000;
      chk("t5_pend_pre", 32'(pending), 32'h6);
      chk("t5_busy_pre", 32'(busy),    32'd1);
      reset = 1'b1;
      chk("t5_trig_rst", 32'(trigger), 32'd0);
      tick(1);
      reset = 1'b0;
      chk("t5_busy_post", 32'(busy),    32'd0);
      chk("t5_pend_post", 32'(pending), 32'h0);
      for (int k = 0; k < 10; k++) begin
         chk("t5_no_trig", 32'(trigger), 32'd0);
         tick(1);
      end
      req = 4'b0100;
      tick(1);
      req = 4'b0000;
      chk("t5_trig_early", 32'(trigger), 32'd0);
      tick(1);
      chk("t5_trig_new", 32'(trigger), 32'd1);
      chk("t5_sel_new",  32'(sel),     32'd2);

      // req[3] held for 300 cycles keeps pending[3] set; counter saturates.
      $display("txn saturate: req[3] held 300 cycles");
      do_reset();
      req = 4'b1000;
      tick(300);
      req = 4'b0000;
`ifdef PWM_FADE_SCHED_STATS_EN
      exp_coal = 32'hFF00_0000;
`else
      exp_coal = 32'h0;
`endif
      chk("t6_coal_sat", coalesce_cnt, exp_coal);
      chk("t6_pend", 32'(pending), 32'h8);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/pwm_fade_sched.md
PWM_FADE_SCHED -- requirements
Module: pwm_fade_sched

Interface
REQ-001 Parameter NUM_REQ, default 4, number of event requesters sharing one fade LED; range 2..8.
REQ-002 Parameter SEL_W, default 2, width of the sel output; SHALL equal ceil(log2(NUM_REQ)).
REQ-003 Parameter HOLD_CYCLES, default 16777216, minimum clk cycles between successive triggers; range 1..2^32-1.
REQ-004 clk  input  1  sole clock, all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req  input  NUM_REQ  per-requester single-cycle event pulses; a bit high for several cycles counts as one event per cycle.
REQ-007 trigger  output  1  one-cycle pulse to the fade datapath, restarting fade at full brightness.
REQ-008 sel  output  SEL_W  index of the requester that owns the current fade, e.g. colour/LED select; valid from the trigger cycle until the next trigger.
REQ-009 busy  output  1  high while a fade hold window is in progress (state FIRE or HOLD).
REQ-010 pending  output  NUM_REQ  registered sticky pending-event flags.
REQ-011 coalesce_cnt  output  8*NUM_REQ  per-requester coalesced-event counters, requester i at bits [8i+7:8i].

Function
REQ-012 pending[i] SHALL set on the edge after req[i] is sampled high.
REQ-013 pending[i] SHALL clear on the edge leaving FIRE for winner i, unless req[i] is high that same cycle, in which case it SHALL stay set.
REQ-014 State machine: IDLE, FIRE, HOLD; registered state; encoding free.
REQ-015 IDLE: if pending is nonzero, select the winner round-robin starting at last_grant+1 (mod NUM_REQ), register it into sel and last_grant, and go to FIRE; otherwise stay in IDLE.
REQ-016 FIRE: lasts exactly one cycle; trigger=1; load the hold counter with HOLD_CYCLES-1; go to HOLD.
REQ-017 HOLD: decrement the hold counter each cycle; when the counter equals 0, go to IDLE on that edge.
REQ-018 Trigger spacing: consecutive trigger pulses SHALL be at least HOLD_CYCLES+2 cycles apart (FIRE, then HOLD_CYCLES hold cycles, then one IDLE arbitration cycle).
REQ-019 Latency: req high in cycle t with the block idle and no other pending -> trigger high in cycle t+2.
REQ-020 trigger is 0 in every state other than FIRE; busy=1 in FIRE and HOLD.
REQ-021 sel holds its value outside FIRE, i.e. the last winner is retained.
REQ-022 Requests arriving during FIRE/HOLD SHALL only set pending; they are never dropped, and multiple events per requester merge into one pending flag.
REQ-023 Simultaneous requests on all lines from idle: grants SHALL occur in order last_grant+1, +2, ..., one per hold window.
REQ-024 The hold counter is 32 bits and SHALL never wrap; HOLD_CYCLES=1 gives a hold window of exactly one cycle.

Reset
REQ-025 While reset is high: state=IDLE, trigger=0, busy=0, sel=0, pending=0, last_grant=NUM_REQ-1 (so the first grant is requester 0), hold counter=0, coalesce_cnt=0.
REQ-026 Reset asserted mid-FIRE/HOLD SHALL abort the window; no trigger is issued in the cycle reset is high; req is ignored during reset.
REQ-027 After reset deasserts, the block behaves as from power-up; the first trigger comes no earlier than 2 cycles after the first sampled req.

Configuration
REQ-028 Macro PWM_FADE_SCHED_STATS_EN defined: coalesce_cnt[i] increments, saturating at 255, each cycle req[i] is high while pending[i] is already 1 and is not being cleared that cycle.
REQ-029 Macro PWM_FADE_SCHED_STATS_EN undefined: coalesce_cnt SHALL be constant 0 and no counter registers SHALL be implemented; all other behaviour is identical.

Verification
REQ-030 Bench parameters are HOLD_CYCLES=4, NUM_REQ=4. After reset, pulse req=0001 at cycle 10 -> trigger=1 at cycle 12 with sel=0, busy=1 in cycles 12..16, busy=0 at cycle 17.
REQ-031 From idle, req=1111 for one cycle -> four triggers spaced 6 cycles apart with sel sequence 0,1,2,3; pending reads 1111, then 1110, 1100, 1000, 0000.
REQ-032 req[2] pulses 3 times during a HOLD window for requester 1 -> exactly one later trigger with sel=2; with the macro defined, coalesce_cnt[2]=2; without the macro, coalesce_cnt=0.
REQ-033 req[0] is high in the same cycle requester 0's FIRE clears it -> pending[0] stays 1 and requester 0 is granted again after the other pending requesters.
REQ-034 Assert reset for one cycle during HOLD with pending=0110 -> next cycle state=IDLE, busy=0, pending=0, and no trigger until a new req.
REQ-035 With the macro defined, hold req[3] high for 300 cycles while pending[3] is held set by a long hold window -> coalesce_cnt[3] saturates at 255.
